// File: rtl/move_button_decoder.sv
// Conditions four raw direction buttons (synchronise, debounce, press detect,
// arbitrate) and delivers one move per press through a one-deep valid/ready slot.
module move_button_decoder #(
    parameter int DEBOUNCE_CYCLES = 65536,
    parameter int CNT_W           = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] btn_raw,
    input  logic       move_ready,
    output logic       move_valid,
    output logic [1:0] move_dir,
    output logic [3:0] btn_level,
    output logic [7:0] drop_count
);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [3:0]       r_sync1;
    logic [3:0]       r_sync2;
    logic [CNT_W-1:0] r_cnt [4];
    logic [3:0]       r_level;
    logic             r_valid;
    logic [1:0]       r_dir;
    logic [7:0]       r_drop;

    logic [3:0] w_press;
    logic       w_any_press;
    logic [1:0] w_winner;
    logic [2:0] w_press_cnt;
    logic       w_slot_free;
    logic [2:0] w_drops;
    logic [8:0] w_drop_sum;

    // NOTE: flops use non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= btn_raw;
            r_sync2 <= r_sync1;
        end
    end

    // NOTE: the counter array is tiny, so it is cleared by reset like any other flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_level <= '0;
            for (int i = 0; i < 4; i++) r_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (r_sync2[i] == r_level[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == CNT_LAST) begin
                    r_level[i] <= r_sync2[i];
                    r_cnt[i]   <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // NOTE: every signal driven here gets a default first, so no latch is inferred.
    always_comb begin
        w_press     = '0;
        w_press_cnt = '0;
        w_winner    = '0;
        for (int i = 0; i < 4; i++) begin
            w_press[i]  = r_sync2[i] && !r_level[i] && (r_cnt[i] == CNT_LAST);
            w_press_cnt = w_press_cnt + {2'b00, w_press[i]};
        end
        for (int i = 3; i >= 0; i--) begin
            if (w_press[i]) w_winner = 2'(i);
        end
        w_any_press = |w_press;
        w_slot_free = !r_valid || move_ready;
        if (!w_any_press)    w_drops = '0;
        else if (w_slot_free) w_drops = w_press_cnt - 3'd1;
        else                 w_drops = w_press_cnt;
        w_drop_sum = {1'b0, r_drop} + {6'b0, w_drops};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_dir   <= '0;
            r_drop  <= '0;
        end else begin
            if (w_any_press && w_slot_free) begin
                r_valid <= 1'b1;
                r_dir   <= w_winner;
            end else if (r_valid && move_ready) begin
                r_valid <= 1'b0;
            end
            r_drop <= w_drop_sum[8] ? 8'hFF : w_drop_sum[7:0];
        end
    end

    assign move_valid = r_valid;
    assign move_dir   = r_dir;
    assign btn_level  = r_level;
    assign drop_count = r_drop;
endmodule

// File: tb/tb_move_button_decoder.sv
// Bench for move_button_decoder: directed scenarios plus randomized traffic
// checked against a window-based behavioural model.
module tb_move_button_decoder;
    localparam int D  = 4;
    localparam int CW = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] btn_raw = '0;
    logic       move_ready = 1'b0;
    logic       move_valid;
    logic [1:0] move_dir;
    logic [3:0] btn_level;
    logic [7:0] drop_count;

    int n_tests = 0;
    int n_fail  = 0;

    move_button_decoder #(.DEBOUNCE_CYCLES(D), .CNT_W(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_raw    (btn_raw),
        .move_ready (move_ready),
        .move_valid (move_valid),
        .move_dir   (move_dir),
        .btn_level  (btn_level),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    // Model: a level flips once the last D synchronised samples all disagree with it.
    logic [3:0] m_level, m_d1, m_d2;
    logic       m_valid;
    logic [1:0] m_dir;
    int         m_drop;
    logic [3:0] m_win[$];

    task automatic model_reset();
        m_level = '0; m_d1 = '0; m_d2 = '0;
        m_valid = 1'b0; m_dir = '0; m_drop = 0;
        m_win.delete();
    endtask

    task automatic model_edge();
        logic [3:0] s, pressed;
        int np, drops;
        bit all_differ, found;
        s = m_d2; m_d2 = m_d1; m_d1 = btn_raw;
        m_win.push_back(s);
        if (m_win.size() > D) void'(m_win.pop_front());
        pressed = '0;
        if (m_win.size() == D) begin
            for (int i = 0; i < 4; i++) begin
                all_differ = 1'b1;
                foreach (m_win[k]) if (m_win[k][i] == m_level[i]) all_differ = 1'b0;
                if (all_differ) begin
                    if (!m_level[i]) pressed[i] = 1'b1;
                    m_level[i] = ~m_level[i];
                end
            end
        end
        np = $countones(pressed);
        drops = 0;
        if (np > 0) begin
            if (!m_valid || move_ready) begin
                m_valid = 1'b1;
                found = 1'b0;
                for (int i = 0; i < 4; i++) if (pressed[i] && !found) begin m_dir = 2'(i); found = 1'b1; end
                drops = np - 1;
            end else begin
                drops = np;
            end
        end else if (m_valid && move_ready) begin
            m_valid = 1'b0;
        end
        m_drop = (m_drop + drops > 255) ? 255 : m_drop + drops;
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            if (!rst_n) model_reset(); else model_edge();
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step(2);
        n_tests++; if (move_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", move_valid); end
        n_tests++; if (move_dir !== 2'd0) begin n_fail++; $display("FAIL reset_dir: got %0d expected 0", move_dir); end
        n_tests++; if (btn_level !== 4'b0000) begin n_fail++; $display("FAIL reset_level: got %b expected 0000", btn_level); end
        n_tests++; if (drop_count !== 8'd0) begin n_fail++; $display("FAIL reset_drop: got %0d expected 0", drop_count); end
        rst_n = 1'b1;
        step(3);
    endtask

    task automatic test_latency();
        int seen;
        btn_raw = 4'b0001;
        step(D + 1);
        n_tests++; if (btn_level !== 4'b0000 || move_valid !== 1'b0) begin n_fail++; $display("FAIL latency_early: level %b valid %b expected 0000/0", btn_level, move_valid); end
        step(1);
        n_tests++; if (btn_level !== 4'b0001) begin n_fail++; $display("FAIL latency_level: got %b expected 0001", btn_level); end
        n_tests++; if (move_valid !== 1'b1 || move_dir !== 2'd0) begin n_fail++; $display("FAIL latency_move: valid %b dir %0d expected 1/0", move_valid, move_dir); end
        step(2);
        move_ready = 1'b1;
        step(1);
        move_ready = 1'b0;
        n_tests++; if (move_valid !== 1'b0) begin n_fail++; $display("FAIL latency_accept: valid %b expected 0", move_valid); end
        seen = 0;
        for (int c = 0; c < 100; c++) begin
            step(1);
            if (move_valid !== 1'b0) seen++;
        end
        n_tests++; if (seen != 0 || btn_level !== 4'b0001) begin n_fail++; $display("FAIL held_no_repeat: valid cycles %0d level %b expected 0/0001", seen, btn_level); end
        btn_raw = 4'b0000;
        step(D + 3);
        n_tests++; if (btn_level !== 4'b0000 || move_valid !== 1'b0) begin n_fail++; $display("FAIL release: level %b valid %b expected 0000/0", btn_level, move_valid); end
    endtask

    task automatic test_bounce();
        btn_raw = 4'b1000; step(3);
        btn_raw = 4'b0000; step(1);
        btn_raw = 4'b1000; step(D + 1);
        n_tests++; if (btn_level[3] !== 1'b0) begin n_fail++; $display("FAIL bounce_early: level[3] %b expected 0", btn_level[3]); end
        step(1);
        n_tests++; if (btn_level[3] !== 1'b1) begin n_fail++; $display("FAIL bounce_level: level[3] %b expected 1", btn_level[3]); end
        n_tests++; if (move_valid !== 1'b1 || move_dir !== 2'd3 || drop_count !== 8'd0) begin n_fail++; $display("FAIL bounce_move: valid %b dir %0d drop %0d expected 1/3/0", move_valid, move_dir, drop_count); end
        move_ready = 1'b1; step(1); move_ready = 1'b0;
        btn_raw = 4'b0000; step(D + 3);
    endtask

    task automatic test_simultaneous();
        btn_raw = 4'b0110;
        step(D + 2);
        n_tests++; if (move_valid !== 1'b1 || move_dir !== 2'd1) begin n_fail++; $display("FAIL simul_move: valid %b dir %0d expected 1/1", move_valid, move_dir); end
        n_tests++; if (drop_count !== 8'd1) begin n_fail++; $display("FAIL simul_drop: got %0d expected 1", drop_count); end
        move_ready = 1'b1; step(1); move_ready = 1'b0;
        n_tests++; if (move_valid !== 1'b0) begin n_fail++; $display("FAIL simul_accept: valid %b expected 0", move_valid); end
        btn_raw = 4'b0000; step(D + 3);
    endtask

    task automatic test_stall_drop();
        int d0;
        d0 = m_drop;
        btn_raw = 4'b0001; step(D + 2);
        btn_raw = 4'b0000; step(D + 3);
        n_tests++; if (btn_level !== 4'b0000 || move_valid !== 1'b1) begin n_fail++; $display("FAIL stall_release: level %b valid %b expected 0000/1", btn_level, move_valid); end
        btn_raw = 4'b0100; step(D + 2);
        n_tests++; if (btn_level !== 4'b0100) begin n_fail++; $display("FAIL stall_level: got %b expected 0100", btn_level); end
        n_tests++; if (move_valid !== 1'b1 || move_dir !== 2'd0) begin n_fail++; $display("FAIL stall_hold: valid %b dir %0d expected 1/0", move_valid, move_dir); end
        n_tests++; if (drop_count !== 8'(d0 + 1)) begin n_fail++; $display("FAIL stall_drop: got %0d expected %0d", drop_count, d0 + 1); end
        move_ready = 1'b1; step(1); move_ready = 1'b0;
        n_tests++; if (move_valid !== 1'b0) begin n_fail++; $display("FAIL stall_accept: valid %b expected 0", move_valid); end
        btn_raw = 4'b0000; step(D + 3);
    endtask

    task automatic test_back_to_back();
        int d0;
        d0 = m_drop;
        btn_raw = 4'b0001; step(D + 2);
        btn_raw = 4'b0101; step(D + 1);
        n_tests++; if (move_valid !== 1'b1 || move_dir !== 2'd0 || btn_level[2] !== 1'b0) begin n_fail++; $display("FAIL b2b_before: valid %b dir %0d level %b expected 1/0/0xx1", move_valid, move_dir, btn_level); end
        move_ready = 1'b1; step(1); move_ready = 1'b0;
        n_tests++; if (btn_level[2] !== 1'b1 || move_valid !== 1'b1 || move_dir !== 2'd2) begin n_fail++; $display("FAIL b2b_load: level %b valid %b dir %0d expected 01x1/1/2", btn_level, move_valid, move_dir); end
        n_tests++; if (drop_count !== 8'(d0)) begin n_fail++; $display("FAIL b2b_drop: got %0d expected %0d", drop_count, d0); end
        move_ready = 1'b1; step(1); move_ready = 1'b0;
        btn_raw = 4'b0000; step(D + 3);
    endtask

    task automatic test_random();
        for (int c = 0; c < 800; c++) begin
            for (int i = 0; i < 4; i++) if ($urandom_range(0, 7) == 0) btn_raw[i] = ~btn_raw[i];
            move_ready = 1'($urandom_range(0, 1));
            step(1);
            n_tests++; if (btn_level !== m_level) begin n_fail++; $display("FAIL rand_level @%0d: got %b expected %b", c, btn_level, m_level); end
            n_tests++; if (move_valid !== m_valid) begin n_fail++; $display("FAIL rand_valid @%0d: got %b expected %b", c, move_valid, m_valid); end
            if (m_valid) begin
                n_tests++; if (move_dir !== m_dir) begin n_fail++; $display("FAIL rand_dir @%0d: got %0d expected %0d", c, move_dir, m_dir); end
            end
            n_tests++; if (drop_count !== 8'(m_drop)) begin n_fail++; $display("FAIL rand_drop @%0d: got %0d expected %0d", c, drop_count, m_drop); end
        end
        btn_raw = 4'b0000; move_ready = 1'b1; step(D + 3);
        move_ready = 1'b0;
    endtask

    task automatic test_saturate();
        for (int k = 0; k < 100; k++) begin
            btn_raw = 4'b1111; step(D + 2);
            btn_raw = 4'b0000; step(D + 2);
            n_tests++; if (drop_count !== 8'(m_drop)) begin n_fail++; $display("FAIL sat_track @%0d: got %0d expected %0d", k, drop_count, m_drop); end
        end
        n_tests++; if (drop_count !== 8'd255) begin n_fail++; $display("FAIL sat_final: got %0d expected 255", drop_count); end
    endtask

    task automatic test_async_reset();
        btn_raw = 4'b0010;
        step(3);
        #2 rst_n = 1'b0;
        #1;
        n_tests++; if (move_valid !== 1'b0 || move_dir !== 2'd0) begin n_fail++; $display("FAIL async_move: valid %b dir %0d expected 0/0", move_valid, move_dir); end
        n_tests++; if (btn_level !== 4'b0000 || drop_count !== 8'd0) begin n_fail++; $display("FAIL async_state: level %b drop %0d expected 0000/0", btn_level, drop_count); end
        @(negedge clk);
        step(2);
        rst_n = 1'b1;
        step(D + 1);
        n_tests++; if (btn_level !== 4'b0000) begin n_fail++; $display("FAIL rst_relatch_early: level %b expected 0000", btn_level); end
        step(1);
        n_tests++; if (btn_level !== 4'b0010 || move_valid !== 1'b1 || move_dir !== 2'd1) begin n_fail++; $display("FAIL rst_relatch: level %b valid %b dir %0d expected 0010/1/1", btn_level, move_valid, move_dir); end
        btn_raw = 4'b0000;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_reset();
        @(negedge clk);
        test_reset();
        test_latency();
        test_bounce();
        test_simultaneous();
        test_stall_drop();
        test_back_to_back();
        test_random();
        test_saturate();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
